// File: rtl/sha256_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sha256_pkg                                                      |
// | Brief    : Shared SHA-256 constants, padder state encoding and helpers.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package sha256_pkg;

    localparam int         WORDS_PER_BLOCK = 16;
    localparam logic [7:0] PAD_BYTE        = 8'h80;

    typedef enum logic [1:0] {
        ST_DATA   = 2'd0,
        ST_ZERO   = 2'd1,
        ST_LEN_HI = 2'd2,
        ST_LEN_LO = 2'd3
    } pad_state_t;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [2:0] keep_popcount(input logic [3:0] k);
        return 3'(k[0]) + 3'(k[1]) + 3'(k[2]) + 3'(k[3]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_msg_padder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sha256_msg_padder                                               |
// | Brief    : Streams a raw message into padded 512-bit SHA-256 blocks.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int BYTE_CNT_W = 32
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] s_data,
    input  logic [3:0]  s_keep,
    input  logic        s_last,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] m_data,
    output logic        m_block_last,
    output logic        m_msg_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        busy
);

    localparam logic [3:0] c_last_widx     = 4'(WORDS_PER_BLOCK - 1);
    localparam logic [3:0] c_last_zero_idx = 4'(WORDS_PER_BLOCK - 3);

    pad_state_t            r_state, w_state_nxt;
    logic [3:0]            r_widx, w_widx_nxt;
    logic [BYTE_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic                  r_pad_pending, w_pad_nxt;
    logic [31:0]           r_m_data, w_data_nxt;
    logic                  r_block_last, w_bl_nxt;
    logic                  r_msg_last, w_ml_nxt;
    logic                  r_m_valid;
    logic                  r_busy, w_busy_nxt;
    logic                  w_load;
    logic                  w_out_free;
    logic                  w_accept;
    logic [2:0]            w_keep_cnt;
    logic [31:0]           w_beat;
    logic [63:0]           w_len;

    assign w_out_free = !r_m_valid || m_ready;
    assign s_ready    = (r_state == ST_DATA) && w_out_free;
    assign w_accept   = s_valid && s_ready;
    assign w_keep_cnt = keep_popcount(s_keep);
    assign w_len      = 64'(r_cnt) << 3;

    // Mask unused lanes; a short final beat carries the terminator in its first empty lane.
    always_comb begin
        w_beat = '0;
        for (int i = 0; i < 4; i++) begin
            if (s_keep[i]) w_beat[8*i +: 8] = s_data[8*i +: 8];
        end
        if (s_last && (s_keep != 4'b1111)) w_beat[{w_keep_cnt[1:0], 3'b000} +: 8] = PAD_BYTE;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_widx_nxt  = r_widx;
        w_cnt_nxt   = r_cnt;
        w_pad_nxt   = r_pad_pending;
        w_load      = 1'b0;
        w_data_nxt  = r_m_data;
        w_bl_nxt    = r_block_last;
        w_ml_nxt    = r_msg_last;
        w_busy_nxt  = r_busy;
        if (r_m_valid && m_ready && r_msg_last) w_busy_nxt = 1'b0;

        case (r_state)
            ST_DATA: begin
                if (w_accept) begin
                    w_load     = 1'b1;
                    w_data_nxt = w_beat;
                    w_bl_nxt   = (r_widx == c_last_widx);
                    w_ml_nxt   = 1'b0;
                    w_widx_nxt = r_widx + 4'd1;
                    w_cnt_nxt  = r_cnt + BYTE_CNT_W'(w_keep_cnt);
                    w_busy_nxt = 1'b1;
                    if (s_last) begin
                        w_pad_nxt = (s_keep == 4'b1111);
                        // A terminator landing in the last zero slot goes straight to the length.
                        if ((s_keep != 4'b1111) && (r_widx == c_last_zero_idx))
                            w_state_nxt = ST_LEN_HI;
                        else
                            w_state_nxt = ST_ZERO;
                    end
                end
            end
            ST_ZERO: begin
                if (w_out_free) begin
                    w_load     = 1'b1;
                    w_data_nxt = r_pad_pending ? 32'(PAD_BYTE) : 32'h0;
                    w_bl_nxt   = (r_widx == c_last_widx);
                    w_ml_nxt   = 1'b0;
                    w_pad_nxt  = 1'b0;
                    w_widx_nxt = r_widx + 4'd1;
                    if (r_widx == c_last_zero_idx) w_state_nxt = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (w_out_free) begin
                    w_load      = 1'b1;
                    w_data_nxt  = bswap32(w_len[63:32]);
                    w_bl_nxt    = 1'b0;
                    w_ml_nxt    = 1'b0;
                    w_widx_nxt  = r_widx + 4'd1;
                    w_state_nxt = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (w_out_free) begin
                    w_load      = 1'b1;
                    w_data_nxt  = bswap32(w_len[31:0]);
                    w_bl_nxt    = 1'b1;
                    w_ml_nxt    = 1'b1;
                    w_widx_nxt  = 4'd0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_DATA;
                end
            end
            default: w_state_nxt = ST_DATA;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state       <= ST_DATA;
            r_widx        <= 4'd0;
            r_cnt         <= '0;
            r_pad_pending <= 1'b0;
            r_m_data      <= 32'h0;
            r_block_last  <= 1'b0;
            r_msg_last    <= 1'b0;
            r_m_valid     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_widx        <= w_widx_nxt;
            r_cnt         <= w_cnt_nxt;
            r_pad_pending <= w_pad_nxt;
            r_m_data      <= w_data_nxt;
            r_block_last  <= w_bl_nxt;
            r_msg_last    <= w_ml_nxt;
            r_busy        <= w_busy_nxt;
            if (w_load)       r_m_valid <= 1'b1;
            else if (m_ready) r_m_valid <= 1'b0;
        end
    end

    assign m_data       = r_m_data;
    assign m_block_last = r_block_last;
    assign m_msg_last   = r_msg_last;
    assign m_valid      = r_m_valid;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: doc/sha256_msg_padder.md
# sha256_msg_padder

Streaming SHA-256 message padder placed directly upstream of the `sha256_axi` core's message-word input at offset 0x10. It accepts a raw message as 32-bit little-endian-packed words and emits complete 512-bit blocks as 16-word bursts. Each block carries the 0x80 terminator, zero fill and the 64-bit bit-length, encoded exactly as the core expects. Software or DMA then streams only payload, with no manual padding.

## Interface
- `BYTE_CNT_W`, default 32: width of the message byte counter. Bit length is `{cnt, 3'b0}`, zero-extended to 64.
- `aclk`  in  1  clock; all logic is rising-edge.
- `areset`  in  1  synchronous, active-high reset.
- `s_data`  in  32  message word. Byte 0 of the word is in `[7:0]`, byte 3 in `[31:24]`.
- `s_keep`  in  4  valid lanes. Must be 4'b1111 except on the `s_last` beat, where 0000/0001/0011/0111/1111 are legal.
- `s_last`  in  1  final beat of the message.
- `s_valid` in 1, `s_ready` out 1: input handshake.
- `m_data`  out  32  padded word, same byte lane order as `s_data`.
- `m_block_last`  out  1  asserted with word 15 of every block.
- `m_msg_last`  out  1  asserted with word 15 of the final block.
- `m_valid` out 1, `m_ready` in 1: output handshake.
- `busy`  out  1  high from the first accepted beat until the final word is accepted.

## Operation
- States: DATA, ZERO, LEN_HI, LEN_LO.
- `widx` (4 bits) counts output words within the current block and wraps 15→0.
- `cnt` (`BYTE_CNT_W` bits) accumulates popcount(`s_keep`) for each accepted beat.
- DATA:
  - Each accepted beat is forwarded with lanes outside `s_keep` forced to 0.
  - On `s_last` with `s_keep`≠1111, lane popcount(`s_keep`) is set to 0x80. This covers keep=0000, where `m_data`=0x00000080. Next state is ZERO.
  - On `s_last` with `s_keep`=1111, the word is forwarded unchanged. A flag `pad_pending` is set so the first ZERO word is 0x00000080.
- ZERO: emits 0x00000000, or 0x00000080 while `pad_pending` (cleared on acceptance).
  - Leave for LEN_HI when the word being accepted has `widx`==13.
  - If the terminator word landed at `widx` 14 or 15, ZERO continues through the wrap and into the next block until `widx`==13.
- LEN_HI: emits bswap(len[63:32]) at `widx` 14.
- LEN_LO: emits bswap(len[31:0]) at `widx` 15 with `m_msg_last`=1, then returns to DATA.
- On leaving LEN_LO, `cnt` and `widx` clear and `busy` drops.
- bswap reverses byte order. The length is big-endian per FIPS 180-4 and is packed with the same little-endian lane convention as the data.
- Total output words per message: 16·⌈(bytes+9)/64⌉.
- `cnt` wraps silently modulo 2^`BYTE_CNT_W`; no overflow flag.

## Timing
- The output is one register stage: a beat accepted at edge N appears on `m_data` after edge N.
- Holding rule: while `m_valid`=1 and `m_ready`=0, `m_data` and all `m_*` flags stay stable.
- `s_ready` = (state==DATA) && (!`m_valid` || `m_ready`).
- `s_ready` is 0 in ZERO/LEN_HI/LEN_LO, so no input is accepted during padding.
- Full throughput is one word per cycle when `m_ready`=1, including back-to-back messages. DATA after LEN_LO accepts the next message on the cycle LEN_LO's word is accepted.
- Reset values: `m_valid`=0, `m_data`=0, `m_block_last`=0, `m_msg_last`=0, `busy`=0, state=DATA, `cnt`=0, `widx`=0, `pad_pending`=0.
- `areset` mid-message (any state) aborts the message. Everything returns to reset values on the next edge and the partial block is discarded; downstream must also be reset.

## Structure
- Shared package `sha256_pkg`:
  - `WORDS_PER_BLOCK`=16
  - `PAD_BYTE`=8'h80
  - state enum `pad_state_t`
  - function `bswap32`
  - function `keep_popcount`
- No sub-module; a single module with an FSM plus output register.

## Test plan
- 64-byte message as 16 words 0x64343962…0x39656463, all keep=1111, `s_last` on word 16 → 32 output words. Word 16 = 0x00000080, words 17–30 = 0, word 31 = 0x00020000. `m_block_last` on words 15 and 31, `m_msg_last` only on 31. Feeding these to the core yields 049da052…8f00249c.
- "abc": one beat 0x00636261, keep=0111, last → word 0 = 0x80636261, words 1–14 = 0, word 15 = 0x18000000, `m_msg_last` on word 15.
- Empty message: keep=0000, last → word 0 = 0x00000080, words 1–15 = 0.
- 56-byte message (14 full words) → 32 words. Word 14 = 0x80, words 15–29 = 0, word 31 = 0xC0010000.
- Random `m_ready` toggling (50%) over 3 back-to-back random-length messages:
  - output matches the reference model;
  - no word lost or duplicated;
  - `m_*` stable while stalled.
- `areset` asserted for 1 cycle while in ZERO → next cycle `m_valid`=0, `busy`=0, `s_ready`=1. A following "abc" message pads correctly.
